// File: rtl/act_share_arbiter.sv
// Round-robin arbiter sharing one pipelined activation unit among NUM_REQ requesters.
// Issued samples carry a requester tag delayed by ACT_LATENCY to route unit results back.
module act_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ACT_LATENCY = 1,
  parameter int BURST_LEN   = 2,
  parameter int ID_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_act_data_in,
  output logic                          o_act_valid_in,
  input  logic [DATA_WIDTH-1:0]         i_act_data_out,
  input  logic                          i_act_valid_out,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic                          o_busy
);
  localparam int BCW = $clog2(BURST_LEN) + 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                              r_state, w_state_nxt;
  logic [ID_W-1:0]                     r_owner, w_owner_nxt;
  logic [ID_W-1:0]                     r_rr_ptr, w_rr_ptr_nxt;
  logic [BCW-1:0]                      r_beat_cnt, w_beat_cnt_nxt;
  logic                                w_found;
  logic [ID_W-1:0]                     w_rr_idx;
  logic [ID_W-1:0]                     w_grant_id;
  logic                                w_xfer;
  int                                  w_idx;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  w_req_data;
  logic [ACT_LATENCY-1:0]              r_tag_vld;
  logic [ACT_LATENCY-1:0][ID_W-1:0]    r_tag_id;
  logic                                w_tag_vld_last;
  logic [ID_W-1:0]                     w_tag_id_last;

  function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  assign w_req_data = i_req_data;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_rr_idx = r_rr_ptr;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_rr_idx = ID_W'(w_idx);
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    w_grant_id  = r_owner;
    if (i_rst_n && i_enable) begin
      if (r_state == S_LOCKED) begin
        o_req_ready[r_owner] = 1'b1;
      end else if (w_found) begin
        o_req_ready[w_rr_idx] = 1'b1;
        w_grant_id            = w_rr_idx;
      end
    end
  end

  assign w_xfer         = |(o_req_ready & i_req_valid);
  assign o_act_valid_in = w_xfer;
  assign o_act_data_in  = w_xfer ? w_req_data[w_grant_id] : '0;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    if (i_enable) begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            w_owner_nxt    = w_grant_id;
            w_beat_cnt_nxt = BCW'(1);
            if (BURST_LEN == 1) w_rr_ptr_nxt = f_next(w_grant_id);
            else                w_state_nxt  = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (w_xfer) begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            if (int'(r_beat_cnt) + 1 == BURST_LEN) begin
              w_state_nxt  = S_IDLE;
              w_rr_ptr_nxt = f_next(r_owner);
            end
          end else begin
            // Owner dropped valid: release the lock, costing one bubble.
            w_state_nxt  = S_IDLE;
            w_rr_ptr_nxt = f_next(r_owner);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Tag shift register mirrors the activation unit's pipeline depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= w_xfer;
      r_tag_id[0]  <= w_grant_id;
      for (int s = 1; s < ACT_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  assign w_tag_vld_last = r_tag_vld[ACT_LATENCY-1];
  assign w_tag_id_last  = r_tag_id[ACT_LATENCY-1];

  always_comb begin
    o_rsp_valid = '0;
    if (i_rst_n && i_act_valid_out && w_tag_vld_last) o_rsp_valid[w_tag_id_last] = 1'b1;
  end

  assign o_rsp_id   = i_rst_n ? w_tag_id_last : '0;
  assign o_rsp_data = i_rst_n ? i_act_data_out : '0;
  assign o_busy     = o_act_valid_in | (|r_tag_vld);

  // The unit's valid must line up with the tag pipe; the tag still gates routing if not.
  a_tag_align: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_act_valid_out == w_tag_vld_last);

endmodule

// File: tb/tb_act_share_arbiter.sv
// Randomized scoreboard bench for act_share_arbiter with a ReLU activation unit model.
module tb_act_share_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int BL  = 2;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      act_data_in;
  logic               act_valid_in;
  logic [DW-1:0]      act_data_out;
  logic               act_valid_out;
  logic [NR-1:0]      rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               busy;

  always #5 clk = ~clk;

  act_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACT_LATENCY(LAT), .BURST_LEN(BL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
    .o_act_data_in(act_data_in), .o_act_valid_in(act_valid_in),
    .i_act_data_out(act_data_out), .i_act_valid_out(act_valid_out),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_id(rsp_id), .o_busy(busy)
  );

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

  // Activation unit: ReLU behind a LAT-deep pipeline.
  logic [LAT-1:0] u_vld;
  logic [DW-1:0]  u_dat [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_vld <= '0;
      for (int s = 0; s < LAT; s++) u_dat[s] <= '0;
    end else begin
      u_vld    <= {u_vld[LAT-2:0], act_valid_in};
      u_dat[0] <= relu(act_data_in);
      for (int s = 1; s < LAT; s++) u_dat[s] <= u_dat[s-1];
    end
  end
  assign act_valid_out = u_vld[LAT-1];
  assign act_data_out  = u_dat[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [DW-1:0] data; int due; } exp_t;
  exp_t q[$];
  int   iss_log[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference arbitration state: lock holder, beats taken, round-robin start.
  bit m_locked;
  int m_owner, m_beats, m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit en, input logic [NR-1:0] v, input logic [NR*DW-1:0] d);
    int g;
    logic [NR-1:0] exp_rdy;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    enable = en; req_valid = v; req_data = d;
    #1;
    g = -1; exp_rdy = '0;
    if (en) begin
      if (m_locked) begin
        exp_rdy[m_owner] = 1'b1;
        if (v[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NR; k++) if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
    end
    exp_d = (g >= 0) ? req_data[g*DW +: DW] : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("act_valid_in", 32'(act_valid_in), 32'(g >= 0));
    chk("act_data_in", 32'(act_data_in), 32'(exp_d));
    chk("busy", 32'(busy), 32'((g >= 0) || (q.size() > 0)));
    for (int i = 0; i < NR; i++) if (act_valid_in && req_ready[i]) iss_log.push_back(i);
    if (g >= 0) q.push_back('{g, relu(exp_d), cyc + LAT});
    if (en) begin
      if (!m_locked) begin
        if (g >= 0) begin
          m_owner = g; m_beats = 1;
          if (BL == 1) m_ptr = (g + 1) % NR;
          else         m_locked = 1'b1;
        end
      end else if (g >= 0) begin
        m_beats++;
        if (m_beats == BL) begin m_locked = 1'b0; m_ptr = (m_owner + 1) % NR; end
      end else begin
        m_locked = 1'b0; m_ptr = (m_owner + 1) % NR;
      end
    end
  endtask

  task automatic step_r(input bit en, input logic [NR-1:0] v);
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = DW'($urandom);
    step(en, v, d);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_act_valid_in", 32'(act_valid_in), 0);
    chk("rst_act_data_in", 32'(act_data_in), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    q.delete();
    m_locked = 1'b0; m_owner = 0; m_beats = 0; m_ptr = 0;
    enable = 1'b0; req_valid = '0;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Response monitor: every cycle, either the oldest issued sample is due or nothing is.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      chk("rsp_valid_in_reset", 32'(rsp_valid), 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b0; req_valid = '0; req_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    do_reset(2);

    // Single beat from requester 0.
    step(1'b1, 4'b0001, {48'h0, 16'h0100});
    repeat (LAT + 2) step_r(1'b1, 4'b0000);

    // Full contention from a fresh pointer: ids 0,0,1,1,2,2,3,3,...
    do_reset(1);
    iss_log.delete();
    repeat (16) step_r(1'b1, 4'b1111);
    chk("contention_len", 32'(iss_log.size()), 16);
    for (int k = 0; k < 16; k++)
      if (k < iss_log.size()) chk("contention_id", 32'(iss_log[k]), 32'((k / 2) % NR));
    repeat (LAT + 1) step_r(1'b1, 4'b0000);

    // Owner drop: 1 locks, drops while 2 waits, then 2 and 3 before 1.
    step_r(1'b1, 4'b0010);
    step_r(1'b1, 4'b0100);
    repeat (6) step_r(1'b1, 4'b1110);
    step_r(1'b1, 4'b0000);

    // Pause mid-burst with a sample in flight, then resume.
    step_r(1'b1, 4'b0000);
    step_r(1'b1, 4'b1111);
    repeat (LAT + 2) step_r(1'b0, 4'b1111);
    repeat (3) step_r(1'b1, 4'b1111);

    // Reset with two samples in the tag pipe.
    repeat (LAT + 1) step_r(1'b1, 4'b0000);
    step_r(1'b1, 4'b1111);
    step_r(1'b1, 4'b1111);
    do_reset(2);
    repeat (LAT + 1) step_r(1'b1, 4'b0000);
    step_r(1'b1, 4'b1111);

    // Alternating requesters 2 and 3 at full rate.
    repeat (12) step_r(1'b1, 4'b1100);

    // Random traffic with occasional pauses.
    repeat (400) step_r($urandom_range(0, 9) != 0, 4'($urandom));

    for (int i = 0; i < 20 && q.size() > 0; i++) step_r(1'b1, 4'b0000);
    @(negedge clk);
    #4;
    chk("drain_queue", 32'(q.size()), 0);
    chk("drain_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
